binary_search_ctrl: RTL and testbench

- Sequential controller that sits on the far side of the team's magnitude-comparator interface.
- It drives the comparator's B operand, the probe, against an unknown operand A.
- It consumes the greater, less and equal flags and binary-searches until it finds the value of A.
- Used wherever a digital value is only observable through compare results: threshold search, SAR-style trimming, calibration loops.

---
 rtl/binary_search_ctrl.sv | 157 +++++++++++++++
 tb/tb_binary_search_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_search_ctrl.sv
// binary_search_ctrl: finds the value of an operand A that can only be observed
// through a magnitude comparator. The controller drives the comparator's B input
// (probe) and reads back the gt/lt/eq flags. It narrows [lo, hi] by one compare
// per cycle until it sees equality, or it stops with an error when the flags
// become inconsistent.
module binary_search_ctrl #(
  parameter  int WIDTH  = 8,
  localparam int ITER_W = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [WIDTH-1:0]  probe,
  input  logic              cmp_gt,
  input  logic              cmp_lt,
  input  logic              cmp_eq,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              error,
  output logic [ITER_W-1:0] iters
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FINISH
  } state_t;

  localparam logic [WIDTH-1:0]  MAX_VAL     = '1;
  localparam logic [WIDTH-1:0]  FIRST_PROBE = MAX_VAL >> 1;
  // A consistent comparator resolves any value in at most WIDTH+1 compares.
  localparam logic [ITER_W-1:0] ITER_LIMIT  = ITER_W'(WIDTH + 1);

  state_t              state, state_d;
  logic [WIDTH-1:0]    lo, lo_d;
  logic [WIDTH-1:0]    hi, hi_d;
  logic [WIDTH-1:0]    probe_d;
  logic [WIDTH-1:0]    result_d;
  logic [ITER_W-1:0]   iters_d;
  logic                error_d;
  logic                abort;

  // Midpoint computed one bit wider so lo + (hi - lo)/2 can never wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] l,
                                                input logic [WIDTH-1:0] h);
    logic [WIDTH:0] sum;
    sum = {1'b0, l} + (({1'b0, h} - {1'b0, l}) >> 1);
    return sum[WIDTH-1:0];
  endfunction

  // State register; reset aborts any search in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Search datapath registers: bounds, probe and the held results.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      lo     <= '0;
      hi     <= '0;
      probe  <= '0;
      result <= '0;
      iters  <= '0;
      error  <= 1'b0;
    end else begin
      lo     <= lo_d;
      hi     <= hi_d;
      probe  <= probe_d;
      result <= result_d;
      iters  <= iters_d;
      error  <= error_d;
    end
  end

  // Next-state and datapath update: one compare is consumed per SEARCH cycle.
  always_comb begin
    // NOTE: everything assigned here gets a default first, so no path infers a latch.
    state_d  = state;
    lo_d     = lo;
    hi_d     = hi;
    probe_d  = probe;
    result_d = result;
    iters_d  = iters;
    error_d  = error;
    abort    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAX_VAL;
          probe_d  = FIRST_PROBE;
          iters_d  = '0;
          error_d  = 1'b0;
          result_d = '0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        iters_d = iters + 1'b1;
        if (!$onehot({cmp_gt, cmp_lt, cmp_eq})) begin
          abort = 1'b1;
        end else if (cmp_eq) begin
          result_d = probe;
          state_d  = FINISH;
        end else if (cmp_gt) begin
          if (probe == MAX_VAL) begin
            abort = 1'b1;
          end else begin
            lo_d = probe + 1'b1;
            if (lo_d > hi) abort = 1'b1;
            else           probe_d = midpoint(lo_d, hi);
          end
        end else begin
          if (probe == '0) begin
            abort = 1'b1;
          end else begin
            hi_d = probe - 1'b1;
            if (lo > hi_d) abort = 1'b1;
            else           probe_d = midpoint(lo, hi_d);
          end
        end

        // Out of compares without equality: the comparator cannot be trusted.
        if (!abort && state_d == SEARCH && iters_d == ITER_LIMIT) abort = 1'b1;

        if (abort) begin
          error_d  = 1'b1;
          result_d = '0;
          state_d  = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded directly from the state.
  always_comb begin
    busy = (state == SEARCH);
    done = (state == FINISH);
  end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Directed bench for binary_search_ctrl: a behavioural comparator answers the
// probes for a chosen A, with hooks to change A or force flags on a given compare.
module tb_binary_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] probe;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic       busy, done, error;
  logic [7:0] result;
  logic [3:0] iters;

  int checks = 0;
  int errors = 0;

  // Comparator model controls.
  logic [7:0] a_val;
  logic       ovr_en;
  logic [2:0] ovr_flags;  // {gt, lt, eq}

  // Per-run observations.
  logic [7:0] probe_log [0:15];
  int         n_cmp;
  int         n_done;

  logic [7:0] exp_55 [0:6] = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h53, 8'h55};
  logic [7:0] exp_ff [0:8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
  logic [7:0] exp_00 [0:7] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  binary_search_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .probe  (probe),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .busy   (busy),
    .done   (done),
    .result (result),
    .error  (error),
    .iters  (iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural magnitude comparator, optionally overridden.
  always_comb begin
    if (ovr_en) begin
      {cmp_gt, cmp_lt, cmp_eq} = ovr_flags;
    end else begin
      cmp_gt = (a_val > probe);
      cmp_lt = (a_val < probe);
      cmp_eq = (a_val == probe);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one search and observe a fixed window long enough for the longest run.
  // chg_at / inj_at / busy_start_at are 1-based compare numbers (0 = unused).
  task automatic run_search(input logic [7:0] a_init, input int chg_at, input logic [7:0] a_new,
                            input int inj_at, input logic [2:0] inj, input int busy_start_at);
    a_val     = a_init;
    ovr_en    = 1'b0;
    ovr_flags = inj;
    n_cmp     = 0;
    n_done    = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      start  = 1'b0;
      ovr_en = 1'b0;
      if (busy) begin
        if (n_cmp < 16) probe_log[n_cmp] = probe;
        n_cmp++;
        if (n_cmp == chg_at)        a_val  = a_new;
        if (n_cmp == inj_at)        ovr_en = 1'b1;
        if (n_cmp == busy_start_at) start  = 1'b1;
      end
      if (done) n_done++;
      @(posedge clk); #1;
    end
    start  = 1'b0;
    ovr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_val = 8'h00;
    ovr_en = 1'b0;
    ovr_flags = 3'b000;
    #12;
    check("rst_probe", probe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_error", error, 0);
    check("rst_iters", iters, 0);
    @(negedge clk) rst_n = 1'b1;

    // A = 0x55, nominal search.
    run_search(8'h55, 0, 8'h00, 0, 3'b000, 0);
    check("a55_ncmp", n_cmp, 7);
    for (int i = 0; i < 7; i++) check($sformatf("a55_probe%0d", i), probe_log[i], exp_55[i]);
    check("a55_done", n_done, 1);
    check("a55_result", result, 8'h55);
    check("a55_iters", iters, 7);
    check("a55_error", error, 0);
    check("a55_probe_hold", probe, 8'h55);

    // A = 0xFF, longest search.
    run_search(8'hFF, 0, 8'h00, 0, 3'b000, 0);
    check("aff_ncmp", n_cmp, 9);
    for (int i = 0; i < 9; i++) check($sformatf("aff_probe%0d", i), probe_log[i], exp_ff[i]);
    check("aff_result", result, 8'hFF);
    check("aff_iters", iters, 9);
    check("aff_error", error, 0);

    // A = 0x00, low edge.
    run_search(8'h00, 0, 8'h00, 0, 3'b000, 0);
    check("a00_ncmp", n_cmp, 8);
    for (int i = 0; i < 8; i++) check($sformatf("a00_probe%0d", i), probe_log[i], exp_00[i]);
    check("a00_result", result, 8'h00);
    check("a00_iters", iters, 8);
    check("a00_error", error, 0);

    // gt and lt both set on the 3rd compare.
    run_search(8'h55, 0, 8'h00, 3, 3'b110, 0);
    check("bad_done", n_done, 1);
    check("bad_error", error, 1);
    check("bad_result", result, 0);
    check("bad_iters", iters, 3);

    // A good search afterwards clears error.
    run_search(8'h55, 0, 8'h00, 0, 3'b000, 0);
    check("recover_error", error, 0);
    check("recover_result", result, 8'h55);

    // lt forced while probe is already 0x00 (8th compare of A = 0).
    run_search(8'h00, 0, 8'h00, 8, 3'b010, 0);
    check("lt0_error", error, 1);
    check("lt0_iters", iters, 8);
    check("lt0_result", result, 0);

    // A moves from 0x10 to 0xF0 before the 4th compare: lo passes hi.
    run_search(8'h10, 4, 8'hF0, 0, 3'b000, 0);
    check("move_error", error, 1);
    check("move_done", n_done, 1);
    check("move_iters", iters, 8);
    check("move_result", result, 0);

    // start pulsed during the 3rd compare is ignored.
    run_search(8'h55, 0, 8'h00, 0, 3'b000, 3);
    check("busy_start_done", n_done, 1);
    check("busy_start_result", result, 8'h55);
    check("busy_start_iters", iters, 7);
    check("busy_start_ncmp", n_cmp, 7);

    // Reset asserted during the 4th compare.
    a_val = 8'h55;
    n_cmp = 0;
    n_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 20 && n_cmp < 4; c++) begin
      if (busy) n_cmp++;
      if (n_cmp < 4) begin
        @(posedge clk); #1;
      end
    end
    check("rst_mid_reached", n_cmp, 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_probe", probe, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("rst_mid_no_done", n_done, 0);
    rst_n = 1'b1;

    // Normal search after reset.
    run_search(8'hA3, 0, 8'h00, 0, 3'b000, 0);
    check("post_rst_done", n_done, 1);
    check("post_rst_result", result, 8'hA3);
    check("post_rst_error", error, 0);
    check("post_rst_probe0", probe_log[0], 8'h7F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
